// File: rtl/nonce_result_arbiter.sv
// Round-robin arbiter that snapshots golden-nonce results from PIPES miner pipes into a FIFO
// for the single host result path. Optional lost-result counter: NONCE_ARB_DROP_CNT_EN.
module nonce_result_arbiter #(
    parameter int unsigned PIPES = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [32*PIPES-1:0]   golden_nonce,
    input  logic [32*PIPES-1:0]   nonce2,
    input  logic [32*PIPES-1:0]   hash2,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [95:0]           out_data,
    output logic [IW-1:0]         out_pipe,
    output logic [4:0]            fifo_count,
    output logic                  overrun,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = (PIPES > 1) ? $clog2(PIPES) : 1;
    localparam int unsigned EW = 96 + IW;

    // Asynchronous assert, synchronous deassert of the internal reset.
    logic rst_meta;
    logic rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    logic [31:0]       last_gn [PIPES];
    logic [95:0]       hold    [PIPES];
    logic [PIPES-1:0]  pending;
    logic [IW-1:0]     rr_ptr;
    logic [EW-1:0]     mem     [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [4:0]        count;
    logic [EW-1:0]     head_q;

    logic [PIPES-1:0]  change;
    logic [PIPES-1:0]  grant_vec;
    logic [PIPES-1:0]  ovr_vec;
    logic              full;
    logic              grant;
    logic [PW-1:0]     gsel;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     rr_nxt;
    logic [PW-1:0]     idx;
    int unsigned       sum;
    logic [EW-1:0]     push_data;
    logic              do_pop;
    logic [AW-1:0]     rd_nxt;
    logic [EW-1:0]     head_d;

    always_comb begin
        change  = '0;
        ovr_vec = '0;
        for (int i = 0; i < PIPES; i++) begin
            change[i] = golden_nonce[32*i +: 32] != last_gn[i];
        end

        // First pending pipe at or after rr_ptr, wrapping mod PIPES.
        full  = (count == 5'(DEPTH));
        grant = 1'b0;
        gsel  = '0;
        idx   = '0;
        sum   = 0;
        for (int unsigned k = 0; k < PIPES; k++) begin
            sum = 32'(rr_ptr) + k;
            if (sum >= PIPES) sum = sum - PIPES;
            idx = PW'(sum);
            if (!grant && pending[idx]) begin
                grant = 1'b1;
                gsel  = idx;
            end
        end
        if (full) grant = 1'b0;

        gidx      = IW'(gsel);
        rr_nxt    = (32'(gsel) + 1 >= PIPES) ? '0 : IW'(32'(gsel) + 1);
        grant_vec = grant ? (PIPES'(1) << gsel) : '0;
        ovr_vec   = change & pending & ~grant_vec;
        push_data = {hold[gsel], gidx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPES; i++) begin
                last_gn[i] <= '0;
                hold[i]    <= '0;
            end
            pending <= '0;
            rr_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            for (int i = 0; i < PIPES; i++) begin
                if (change[i]) begin
                    last_gn[i] <= golden_nonce[32*i +: 32];
                    hold[i]    <= {hash2[32*i +: 32], nonce2[32*i +: 32], golden_nonce[32*i +: 32]};
                    pending[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (grant) rr_ptr <= rr_nxt;
            if (|ovr_vec) overrun <= 1'b1;
        end
    end

    // FIFO with a registered head that tracks the entry at rd_ptr.
    always_comb begin
        do_pop = pop && (count != 5'd0);
        rd_nxt = rd_ptr + AW'(1);
        head_d = head_q;
        if (do_pop) begin
            if (count >= 5'd2) head_d = mem[rd_nxt];
            else if (grant)    head_d = push_data;
        end else if (count == 5'd0 && grant) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (grant)  wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_nxt;
            count  <= count + 5'(grant) - 5'(do_pop);
            head_q <= head_d;
        end
    end

    assign out_valid  = (count != 5'd0);
    assign out_data   = head_q[EW-1:IW];
    assign out_pipe   = head_q[IW-1:0];
    assign fifo_count = count;

`ifdef NONCE_ARB_DROP_CNT_EN
    logic [7:0]  wait_cnt [PIPES];
    logic [7:0]  drop_q;
    logic [7:0]  drop_d;
    logic        long_wait;
    int unsigned inc;
    int unsigned dsum;

    // One count per overwritten snapshot, plus one per cycle any pipe has waited >255 cycles.
    always_comb begin
        long_wait = 1'b0;
        inc       = 0;
        for (int i = 0; i < PIPES; i++) begin
            inc = inc + 32'(ovr_vec[i]);
            if (pending[i] && full && wait_cnt[i] == 8'hFF) long_wait = 1'b1;
        end
        inc    = inc + 32'(long_wait);
        dsum   = 32'(drop_q) + inc;
        drop_d = (dsum > 255) ? 8'hFF : 8'(dsum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPES; i++) wait_cnt[i] <= '0;
            drop_q <= '0;
        end else begin
            for (int i = 0; i < PIPES; i++) begin
                if (pending[i] && full) begin
                    if (wait_cnt[i] != 8'hFF) wait_cnt[i] <= wait_cnt[i] + 8'd1;
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_nonce_result_arbiter.sv
// Directed self-checking bench for nonce_result_arbiter (PIPES=4, DEPTH=4, IW=3).
module tb_nonce_result_arbiter;

    logic         clk;
    logic         reset_n;
    logic [127:0] gn;
    logic [127:0] n2;
    logic [127:0] h2;
    logic         pop;
    logic         out_valid;
    logic [95:0]  out_data;
    logic [2:0]   out_pipe;
    logic [4:0]   fifo_count;
    logic         overrun;
    logic [7:0]   drop_cnt;

    int total = 0;
    int bad   = 0;

    nonce_result_arbiter #(.PIPES(4), .DEPTH(4), .IW(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .golden_nonce (gn),
        .nonce2       (n2),
        .hash2        (h2),
        .pop          (pop),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_pipe     (out_pipe),
        .fifo_count   (fifo_count),
        .overrun      (overrun),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic set_pipe(input int i, input logic [31:0] g, input logic [31:0] n,
                            input logic [31:0] h);
        gn[32*i +: 32] = g;
        n2[32*i +: 32] = n;
        h2[32*i +: 32] = h;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        pop = 1'b0;
        gn = '0;
        n2 = '0;
        h2 = '0;
        #1 reset_n = 1'b0;
        #11;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_pipe", out_pipe, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drop", drop_cnt, 0);
        #11 reset_n = 1'b1;
        repeat (4) tick();

        // Single pipe, two-cycle latency.
        set_pipe(2, 32'h1234ABCD, 32'h55, 32'h0);
        tick();
        chk("single_lat1_valid", out_valid, 0);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, {32'h0, 32'h55, 32'h1234ABCD});
        chk("single_pipe", out_pipe, 2);
        chk("single_count", fifo_count, 1);
        do_pop();
        chk("single_pop_valid", out_valid, 0);
        chk("single_pop_count", fifo_count, 0);
        chk("single_hold_data", out_data, {32'h0, 32'h55, 32'h1234ABCD});

        // Pop while empty.
        do_pop();
        chk("empty_pop_count", fifo_count, 0);
        chk("empty_pop_valid", out_valid, 0);

        // Pipe 0 alone leaves rr_ptr at 1.
        set_pipe(0, 32'h100, 32'h0, 32'h0);
        tick();
        tick();
        chk("rr_setup_pipe", out_pipe, 0);
        chk("rr_setup_gn", out_data[31:0], 32'h100);
        do_pop();
        chk("rr_setup_count", fifo_count, 0);

        // Pipes 0,1,3 together with rr_ptr=1: order 1,3,0; push+pop at count 2.
        set_pipe(0, 32'h200, 32'h0, 32'h0);
        set_pipe(1, 32'h201, 32'h0, 32'h0);
        set_pipe(3, 32'h203, 32'h0, 32'h0);
        tick();
        chk("sim_count0", fifo_count, 0);
        tick();
        chk("sim_count1", fifo_count, 1);
        chk("sim_first_pipe", out_pipe, 1);
        tick();
        chk("sim_count2", fifo_count, 2);
        chk("sim_head_kept", out_data[31:0], 32'h201);
        do_pop();
        chk("pushpop_count", fifo_count, 2);
        chk("pushpop_pipe", out_pipe, 3);
        chk("pushpop_gn", out_data[31:0], 32'h203);
        do_pop();
        chk("sim_third_pipe", out_pipe, 0);
        chk("sim_third_gn", out_data[31:0], 32'h200);
        chk("sim_count_after", fifo_count, 1);
        do_pop();
        chk("sim_drained", out_valid, 0);

        // Fill FIFO; a fifth result waits until a pop frees a slot.
        set_pipe(0, 32'h300, 32'h0, 32'h0);
        set_pipe(1, 32'h301, 32'h0, 32'h0);
        set_pipe(2, 32'h302, 32'h55, 32'h0);
        set_pipe(3, 32'h303, 32'h0, 32'h0);
        repeat (5) tick();
        chk("full_count", fifo_count, 4);
        chk("full_head_pipe", out_pipe, 1);
        chk("full_head_gn", out_data[31:0], 32'h301);
        set_pipe(1, 32'h311, 32'h0, 32'h0);
        tick();
        tick();
        chk("full_wait_count", fifo_count, 4);
        chk("full_wait_overrun", overrun, 0);
        do_pop();
        chk("full_pop_count", fifo_count, 3);
        chk("full_pop_pipe", out_pipe, 2);
        chk("full_pop_gn", out_data[31:0], 32'h302);
        tick();
        chk("full_refill_count", fifo_count, 4);
        chk("full_refill_overrun", overrun, 0);

        // Overrun: pipe 0 changes twice while blocked; newest value kept.
        set_pipe(0, 32'hA, 32'h0, 32'h0);
        tick();
        chk("ovr_first_clean", overrun, 0);
        set_pipe(0, 32'hB, 32'h0, 32'h0);
        tick();
        chk("ovr_flag", overrun, 1);
`ifdef NONCE_ARB_DROP_CNT_EN
        chk("ovr_drop", drop_cnt, 1);
`else
        chk("ovr_drop", drop_cnt, 0);
`endif
        do_pop();
        chk("ovr_pop_count", fifo_count, 3);
        chk("ovr_pop_pipe", out_pipe, 3);
        tick();
        chk("ovr_push_count", fifo_count, 4);
        do_pop();
        chk("ovr_q1_gn", out_data[31:0], 32'h300);
        do_pop();
        chk("ovr_q2_pipe", out_pipe, 1);
        chk("ovr_q2_gn", out_data[31:0], 32'h311);
        do_pop();
        chk("ovr_last_pipe", out_pipe, 0);
        chk("ovr_last_gn", out_data[31:0], 32'hB);
        chk("ovr_last_count", fifo_count, 1);
        do_pop();
        chk("ovr_drained", fifo_count, 0);
        chk("ovr_sticky", overrun, 1);

        // Return to zero is a change.
        set_pipe(3, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk("zero_valid", out_valid, 1);
        chk("zero_pipe", out_pipe, 3);
        chk("zero_data", out_data, 96'h0);

        // Three entries queued plus pipe 1 pending, then asynchronous reset.
        set_pipe(0, 32'hC, 32'h0, 32'h0);
        set_pipe(2, 32'hD, 32'h55, 32'h0);
        tick();
        tick();
        tick();
        chk("midrst_pre_count", fifo_count, 3);
        set_pipe(1, 32'hE, 32'h0, 32'h0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_data", out_data, 96'h0);
        chk("midrst_drop", drop_cnt, 0);
        #1 reset_n = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
